decode_ins_buffer: RTL and testbench

//  Decode-side instruction buffer feeding the immediate extender and the main decoder.

---
 rtl/decode_ins_buffer_pkg.sv | 38 +++
 rtl/decode_ins_buffer_classify.sv | 35 +++
 rtl/decode_ins_buffer.sv | 97 +++++++++
 tb/tb_decode_ins_buffer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/decode_ins_buffer_pkg.sv
// ============================================================================
// Module   : decode_ins_buffer_pkg
// Brief    : Immediate-format codes, RV64 major opcodes and NOP encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package decode_ins_buffer_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_N = 3'd5,
    IMM_R = 3'd6
  } imm_type_t;

  localparam logic [6:0] C_OP_LOAD     = 7'b0000011;
  localparam logic [6:0] C_OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] C_OP_IMM      = 7'b0010011;
  localparam logic [6:0] C_OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] C_OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] C_OP_STORE    = 7'b0100011;
  localparam logic [6:0] C_OP_OP       = 7'b0110011;
  localparam logic [6:0] C_OP_LUI      = 7'b0110111;
  localparam logic [6:0] C_OP_OP_32    = 7'b0111011;
  localparam logic [6:0] C_OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] C_OP_JALR     = 7'b1100111;
  localparam logic [6:0] C_OP_JAL      = 7'b1101111;
  localparam logic [6:0] C_OP_SYSTEM   = 7'b1110011;

  localparam logic [31:0] C_NOP = 32'h00000013;

endpackage

`default_nettype wire

// File: rtl/decode_ins_buffer_classify.sv
// ============================================================================
// Module   : ins_type_classify
// Brief    : Combinational opcode -> immediate format / illegal flag
// Revision : 1.0
// ============================================================================
`default_nettype none

import decode_ins_buffer_pkg::*;

module ins_type_classify (
  input  logic [6:0] i_opcode,
  output imm_type_t  o_type,
  output logic       o_illegal
);

  always_comb begin
    o_type    = IMM_N;
    o_illegal = 1'b0;
    case (i_opcode)
      C_OP_LOAD, C_OP_IMM, C_OP_IMM_32,
      C_OP_JALR, C_OP_SYSTEM:          o_type = IMM_I;
      C_OP_STORE:                      o_type = IMM_S;
      C_OP_BRANCH:                     o_type = IMM_B;
      C_OP_LUI, C_OP_AUIPC:            o_type = IMM_U;
      C_OP_JAL:                        o_type = IMM_J;
      C_OP_OP, C_OP_OP_32:             o_type = IMM_R;
      C_OP_MISC_MEM:                   o_type = IMM_N;
      // Anything else, including compressed encodings (low bits != 2'b11).
      default:                         o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decode_ins_buffer.sv
// ============================================================================
// Module   : decode_ins_buffer
// Brief    : Decode-side {PC, instruction} FIFO with enqueue-time classification
// Revision : 1.0
// ============================================================================
`default_nettype none

import decode_ins_buffer_pkg::*;

module decode_ins_buffer #(
  parameter int DEPTH    = 2,
  parameter int PC_WIDTH = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [PC_WIDTH-1:0] i_in_pc,
  input  logic [31:0]         i_in_ins,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [PC_WIDTH-1:0] o_out_pc,
  output logic [31:0]         o_out_ins,
  output logic [2:0]          o_out_imm_type,
  output logic                o_out_illegal
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [PC_WIDTH-1:0] r_pc      [DEPTH];
  logic [31:0]         r_ins     [DEPTH];
  logic [2:0]          r_type    [DEPTH];
  logic                r_illegal [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  imm_type_t w_type;
  logic      w_illegal;
  logic      w_push;
  logic      w_pop;

  ins_type_classify u_classify (
    .i_opcode  (i_in_ins[6:0]),
    .o_type    (w_type),
    .o_illegal (w_illegal)
  );

  // Ready depends on occupancy only, so decode back-pressure never reaches fetch combinationally.
  assign o_in_ready  = (r_count < C_DEPTH);
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  assign o_out_pc       = r_pc[r_rd_ptr];
  assign o_out_ins      = r_ins[r_rd_ptr];
  assign o_out_imm_type = r_type[r_rd_ptr];
  assign o_out_illegal  = r_illegal[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]      <= '0;
        r_ins[i]     <= C_NOP;
        r_type[i]    <= IMM_I;
        r_illegal[i] <= 1'b0;
      end
    end else if (w_push && !i_flush) begin
      r_pc[r_wr_ptr]      <= i_in_pc;
      r_ins[r_wr_ptr]     <= i_in_ins;
      r_type[r_wr_ptr]    <= w_type;
      r_illegal[r_wr_ptr] <= w_illegal;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_ins_buffer.sv
// ============================================================================
// Module   : tb_decode_ins_buffer
// Brief    : Directed + random bench against a queue-based reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

import decode_ins_buffer_pkg::*;

module tb_decode_ins_buffer;

  localparam int DEPTH    = 2;
  localparam int PC_WIDTH = 64;

  logic                i_clk = 1'b0;
  logic                i_rst, i_flush, i_in_valid, i_out_ready;
  logic [PC_WIDTH-1:0] i_in_pc;
  logic [31:0]         i_in_ins;
  logic                o_in_ready, o_out_valid, o_out_illegal;
  logic [PC_WIDTH-1:0] o_out_pc;
  logic [31:0]         o_out_ins;
  logic [2:0]          o_out_imm_type;

  decode_ins_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_flush        (i_flush),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .i_in_pc        (i_in_pc),
    .i_in_ins       (i_in_ins),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_out_pc       (o_out_pc),
    .o_out_ins      (o_out_ins),
    .o_out_imm_type (o_out_imm_type),
    .o_out_illegal  (o_out_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         ins;
  } entry_t;

  entry_t q[$];
  bit     fresh_reset;
  int     total = 0;
  int     bad   = 0;

  // Expected immediate format straight from the opcode table.
  function automatic logic [3:0] ref_class(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h03 || op == 7'h13 || op == 7'h1B || op == 7'h67 || op == 7'h73) return {1'b0, IMM_I};
    if (op == 7'h23) return {1'b0, IMM_S};
    if (op == 7'h63) return {1'b0, IMM_B};
    if (op == 7'h37 || op == 7'h17) return {1'b0, IMM_U};
    if (op == 7'h6F) return {1'b0, IMM_J};
    if (op == 7'h33 || op == 7'h3B) return {1'b0, IMM_R};
    if (op == 7'h0F) return {1'b0, IMM_N};
    return {1'b1, IMM_N};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: apply inputs, check outputs mid-cycle, advance the model across the edge.
  task automatic step(input logic rst, input logic flush, input logic v,
                      input logic [63:0] pc, input logic [31:0] ins, input logic rdy);
    logic [3:0] cls;
    bit push, pop;
    entry_t e;
    i_rst = rst; i_flush = flush; i_in_valid = v; i_in_pc = pc; i_in_ins = ins; i_out_ready = rdy;
    #4;
    chk("out_valid", 64'(o_out_valid), 64'(q.size() != 0));
    chk("in_ready",  64'(o_in_ready),  64'(q.size() < DEPTH));
    if (q.size() != 0) begin
      cls = ref_class(q[0].ins);
      chk("out_pc",   o_out_pc,               q[0].pc);
      chk("out_ins",  64'(o_out_ins),         64'(q[0].ins));
      chk("imm_type", 64'(o_out_imm_type),    64'(cls[2:0]));
      chk("illegal",  64'(o_out_illegal),     64'(cls[3]));
    end else if (fresh_reset) begin
      chk("rst_pc",   o_out_pc,               64'h0);
      chk("rst_ins",  64'(o_out_ins),         64'h13);
      chk("rst_type", 64'(o_out_imm_type),    64'(IMM_I));
      chk("rst_ill",  64'(o_out_illegal),     64'h0);
    end
    push = v && (q.size() < DEPTH);
    pop  = rdy && (q.size() != 0);
    @(posedge i_clk);
    #1;
    if (rst || flush) begin
      q.delete();
      if (rst) fresh_reset = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc = pc; e.ins = ins;
        q.push_back(e);
        fresh_reset = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 64'h0, 32'h0, rdy);
  endtask

  logic [6:0]  ops [14] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h00};
  logic [31:0] stream [8] = '{32'h000012B7, 32'h00208033, 32'h0000000F, 32'h00112023,
                              32'h00000463, 32'h0080006F, 32'h00A00093, 32'h0040006F};

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    i_rst = 1'b1; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_in_pc = '0; i_in_ins = '0;
    repeat (2) @(posedge i_clk);
    #1;
    q.delete();
    fresh_reset = 1'b1;

    // 1: single addi with decode stalled, then post-reset state check
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h1000, 32'h00A00093, 1'b0);
    idle(1'b1);

    // 2: fill, back-pressure, pop-frees-slot-next-cycle
    step(1'b0, 1'b0, 1'b1, 64'h2000, 32'h00112023, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h2004, 32'h00000463, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h2008, 32'h0080006F, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h2008, 32'h0080006F, 1'b1);
    step(1'b0, 1'b0, 1'b1, 64'h2008, 32'h0080006F, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // 3: streaming push and pop every cycle
    step(1'b0, 1'b0, 1'b1, 64'h3000, stream[0], 1'b1);
    for (int i = 1; i < 8; i++)
      step(1'b0, 1'b0, 1'b1, 64'h3000 + 64'(4*i), stream[i], 1'b1);
    idle(1'b1);

    // 4: illegal opcodes
    step(1'b0, 1'b0, 1'b1, 64'h4000, 32'h0000007F, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h4004, 32'h00000000, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // 5: flush a full buffer with a push offered in the same cycle
    step(1'b0, 1'b0, 1'b1, 64'h5000, 32'h00000463, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h5004, 32'h00112023, 1'b0);
    step(1'b0, 1'b1, 1'b1, 64'h5008, 32'h0080006F, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // 6: reset with one entry held, then push on the first post-reset cycle
    step(1'b0, 1'b0, 1'b1, 64'h6000, 32'h000012B7, 1'b0);
    step(1'b1, 1'b0, 1'b1, 64'h6004, 32'h00208033, 1'b1);
    step(1'b0, 1'b0, 1'b1, 64'h6008, 32'h0080006F, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with occasional flush / reset
    for (int n = 0; n < 400; n++) begin
      r  = $urandom;
      op = ops[$urandom_range(0, 13)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0), {32'h0, $urandom}, {r[31:7], op},
           ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
